// File: rtl/cla_serial_adder_ctrl.sv
// Multi-precision add/subtract that reuses one 4-bit carry-lookahead block
// across the operand nibbles, LS nibble first, with valid/ready on both sides.

module cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);
  logic [3:0] w_p, w_g;
  logic [3:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign w_c[0] = i_c;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign o_c    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);
  assign o_s    = w_p ^ w_c;
endmodule

module cla_serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_a, r_b, r_sum;
  logic            r_carry, r_cout, r_ovf;
  logic [IW-1:0]   r_idx;
  logic [IW+1:0]   w_base;
  logic [3:0]      w_a_nib, w_b_nib, w_s;
  logic            w_c, w_last;

  assign w_base  = {r_idx, 2'b00};
  assign w_a_nib = r_a[w_base +: 4];
  assign w_b_nib = r_b[w_base +: 4];
  assign w_last  = (r_idx == IW'(NIBBLES - 1));

  cla4 u_cla (
    .i_a (w_a_nib),
    .i_b (w_b_nib),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= sub ? ~b : b;
          r_carry <= sub ? 1'b1 : cin;
          r_idx   <= '0;
          r_sum   <= '0;
        end
        RUN: begin
          r_sum[w_base +: 4] <= w_s;
          r_carry            <= w_c;
          if (w_last) begin
            r_cout <= w_c;
            // The MSB of the final sum is w_s[3] this cycle, not yet in r_sum.
            r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_s[3] != r_a[W-1]);
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Directed bench for cla_serial_adder_ctrl (NIBBLES=4) with an expected-result queue.

module tb_cla_serial_adder_ctrl;
  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        q[$];
  exp_t        held;

  cla_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub);
    logic [W-1:0] be;
    logic [W:0]   r;
    exp_t         e;
    be  = msub ? ~mb : mb;
    r   = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
    e.s = r[W-1:0];
    e.c = r[W];
    e.o = (ma[W-1] == be[W-1]) && (r[W-1] != ma[W-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present a request at a negedge and wait for the accept edge.
  task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic dcin, input logic dsub, input bit push);
    int unsigned n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_req", {31'd0, in_ready}, 32'd1);
    a = da; b = db; cin = dcin; sub = dsub; in_valid = 1'b1;
    if (push) q.push_back(model(da, db, dcin, dsub));
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
  endtask

  // Wait for out_valid, check latency and the popped expectation.
  task automatic wait_result(input string tag, input int unsigned lat_exp);
    int unsigned lat;
    exp_t        e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, lat, lat_exp);
    if (q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check({tag, "_sum"},  {16'd0, sum}, {16'd0, e.s});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, e.c});
      check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, e.o});
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    int unsigned seen;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    rst_n = 1'b1;
    check("rst_rel_in_ready", {31'd0, in_ready}, 32'd1);

    drive(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    wait_result("add_basic", 4);
    check("add_basic_const", {16'd0, sum}, 32'h5555);
    handshake("add_basic");

    drive(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1);
    wait_result("ripple_ovf", 4);
    check("ripple_ovf_const", {16'd0, sum}, 32'h8000);
    handshake("ripple_ovf");

    drive(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    wait_result("sub_neg", 4);
    check("sub_neg_const", {16'd0, sum}, 32'hFFFE);
    handshake("sub_neg");

    drive(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    wait_result("sub_cin_ignored", 4);
    handshake("sub_cin_ignored");

    drive(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    wait_result("sub_ovf", 4);
    check("sub_ovf_const", {15'd0, cout, ovf, sum}, {15'd0, 1'b1, 1'b1, 16'h7FFF});
    handshake("sub_ovf");

    // Backpressure: new request presented while DONE is held.
    drive(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    wait_result("bp_first", 4);
    held = model(16'h1234, 16'h4321, 1'b0, 1'b0);
    a = 16'h0F0F; b = 16'h0101; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    q.push_back(model(16'h0F0F, 16'h0101, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_result", {15'd0, cout, ovf, sum}, {15'd0, held.c, held.o, held.s});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_pending_accepted", {31'd0, in_ready}, 32'd0);
    wait_result("bp_pending", 4);
    handshake("bp_pending");

    // Reset while DONE clears the outputs.
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait_result("ripple_carry", 4);
    #1 rst_n = 1'b0;
    #1;
    check("rst_done_result", {14'd0, out_valid, cout, ovf, sum}, 32'd0);
    check("rst_done_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while nibble 2 is being processed aborts the operation.
    drive(16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_run_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_run_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_run_no_pulse", seen, 32'd0);

    drive(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b1);
    wait_result("post_reset", 4);
    check("post_reset_const", {15'd0, cout, ovf, sum}, {15'd0, 1'b0, 1'b0, 16'hBCDE});
    handshake("post_reset");

    check("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
